// File: rtl/sar_search_8b.sv
// Successive-approximation search that recovers an unknown operand by steering an
// external comparator's B input and bisecting on its eq/gt/lt flags.
module sar_search_8b #(
  parameter int WIDTH   = 8,
  parameter int CMP_LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             s,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       nprobe
);

  localparam int               WW       = (CMP_LAT > 0) ? $clog2(CMP_LAT + 1) : 1;
  localparam logic [WW-1:0]    LAT_W    = WW'(CMP_LAT);
  localparam logic [WIDTH:0]   HI_INIT  = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   lo_q, lo_d, hi_q, hi_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             s_q, s_d;
  logic [WIDTH-1:0] probe_q, probe_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       nprobe_q, nprobe_d;
  logic             found_q, found_d, err_q, err_d;
  logic [WIDTH:0]   sum, mid;
  logic [WIDTH-1:0] cur_probe;

  // Flipping the MSB maps the signed range onto an ascending unsigned index.
  function automatic logic [WIDTH-1:0] to_probe(input logic [WIDTH-1:0] u, input logic sgn);
    return sgn ? (u ^ MSB_MASK) : u;
  endfunction

  // One extra bit keeps lo+hi exact at the top of the range.
  assign sum       = lo_q + hi_q;
  assign mid       = sum >> 1;
  assign cur_probe = to_probe(mid[WIDTH-1:0], s_q);

  assign probe   = (state_q == PROBE) ? cur_probe : probe_q;
  assign probe_d = probe;
  assign busy    = (state_q == PROBE);
  assign done    = (state_q == DONE);
  assign found   = found_q;
  assign err     = err_q;
  assign result  = result_q;
  assign nprobe  = nprobe_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      wait_q   <= '0;
      s_q      <= 1'b0;
      probe_q  <= '0;
      result_q <= '0;
      nprobe_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      wait_q   <= wait_d;
      s_q      <= s_d;
      probe_q  <= probe_d;
      result_q <= result_d;
      nprobe_q <= nprobe_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    wait_d   = wait_q;
    s_d      = s_q;
    result_d = result_q;
    nprobe_d = nprobe_q;
    found_d  = found_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          s_d      = s;
          lo_d     = '0;
          hi_d     = HI_INIT;
          wait_d   = '0;
          nprobe_d = '0;
          found_d  = 1'b0;
          err_d    = 1'b0;
          state_d  = PROBE;
        end
      end
      PROBE: begin
        if (wait_q != LAT_W) begin
          wait_d = wait_q + WW'(1);
        end else begin
          wait_d   = '0;
          nprobe_d = nprobe_q + 4'd1;
          unique case ({cmp_eq, cmp_gt, cmp_lt})
            3'b100: begin
              result_d = cur_probe;
              found_d  = 1'b1;
              state_d  = DONE;
            end
            3'b010: begin
              if (mid == hi_q) begin
                err_d   = 1'b1;
                state_d = DONE;
              end else begin
                lo_d = mid + (WIDTH+1)'(1);
              end
            end
            3'b001: begin
              if (mid == lo_q) begin
                err_d   = 1'b1;
                state_d = DONE;
              end else begin
                hi_d = mid - (WIDTH+1)'(1);
              end
            end
            default: begin
              // Zero or multiple flags means the comparator cannot be trusted.
              err_d    = 1'b1;
              result_d = cur_probe;
              state_d  = DONE;
            end
          endcase
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sar_search_8b.sv
// Directed bench for sar_search_8b: a value-domain bisection model predicts every
// probe, the done cycle and the final flags; literal expectations pin the model.
module tb_sar_search_8b;

  logic       clk = 1'b0;
  logic       rst_n, start0, start1, s_in;
  logic       eq0, gt0, lt0, eq1, gt1, lt1;
  logic [7:0] probe0, result0, probe1, result1;
  logic       busy0, done0, found0, err0, busy1, done1, found1, err1;
  logic [3:0] nprobe0, nprobe1;
  logic [7:0] pd1, pd2;

  int         mode;
  logic [7:0] tgt;
  logic       tsgn;
  int         checks, errors;

  logic [7:0] exp_q[$];
  logic       exp_found, exp_err, exp_res_valid;
  logic [7:0] exp_result;
  int         exp_n;
  int         done_j;
  logic [7:0] first_probe;

  always #5 clk = ~clk;

  sar_search_8b #(.WIDTH(8), .CMP_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .s(s_in),
    .cmp_eq(eq0), .cmp_gt(gt0), .cmp_lt(lt0),
    .probe(probe0), .busy(busy0), .done(done0), .found(found0), .err(err0),
    .result(result0), .nprobe(nprobe0));

  sar_search_8b #(.WIDTH(8), .CMP_LAT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .s(s_in),
    .cmp_eq(eq1), .cmp_gt(gt1), .cmp_lt(lt1),
    .probe(probe1), .busy(busy1), .done(done1), .found(found1), .err(err1),
    .result(result1), .nprobe(nprobe1));

  // Comparator environment: mode 0 is a real comparator, others inject faults.
  function automatic logic [2:0] cmpf(input int md, input logic [7:0] t, input logic sg,
                                      input logic [7:0] p);
    int a, b;
    if (sg) begin
      a = $signed(t);
      b = $signed(p);
    end else begin
      a = int'(t);
      b = int'(p);
    end
    case (md)
      1:       return 3'b110;
      2:       return 3'b010;
      3:       return 3'b001;
      4:       return 3'b000;
      default: return {a == b, a > b, a < b};
    endcase
  endfunction

  assign {eq0, gt0, lt0} = cmpf(mode, tgt, tsgn, probe0);
  // Two-cycle comparator latency for the CMP_LAT=2 instance.
  always @(posedge clk) begin
    pd1 <= probe1;
    pd2 <= pd1;
  end
  assign {eq1, gt1, lt1} = cmpf(mode, tgt, tsgn, pd2);
  assign s_in = tsgn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bisection over the natural integer range of the chosen order.
  task automatic build_model(input logic [7:0] t, input logic sg, input int md);
    int lo, hi, mid, tv;
    logic [2:0] f;
    exp_q.delete();
    exp_found = 1'b0; exp_err = 1'b0; exp_res_valid = 1'b0; exp_result = 8'h00; exp_n = 0;
    lo = sg ? -128 : 0;
    hi = sg ? 127 : 255;
    tv = sg ? int'($signed(t)) : int'(t);
    for (int k = 0; k < 20; k++) begin
      mid = (lo + hi) >>> 1;
      exp_q.push_back(8'(mid));
      exp_n++;
      f = (md == 0) ? {tv == mid, tv > mid, tv < mid} : cmpf(md, t, sg, 8'(mid));
      if (f == 3'b100) begin
        exp_found = 1'b1; exp_res_valid = 1'b1; exp_result = 8'(mid); break;
      end else if (f == 3'b010) begin
        if (mid == hi) begin exp_err = 1'b1; break; end
        lo = mid + 1;
      end else if (f == 3'b001) begin
        if (mid == lo) begin exp_err = 1'b1; break; end
        hi = mid - 1;
      end else begin
        exp_err = 1'b1; exp_res_valid = 1'b1; exp_result = 8'(mid); break;
      end
    end
  endtask

  // Drives one search and compares the chosen DUT against the model every cycle.
  task automatic run(input bit sel, input logic [7:0] t, input logic sg, input int md,
                     input bit poke);
    int L, total;
    logic [7:0] pv, rs;
    logic bz, dn, fd, er;
    logic [3:0] np;
    L = sel ? 2 : 0;
    build_model(t, sg, md);
    tgt = t; tsgn = sg; mode = md;
    done_j = -1;
    @(negedge clk);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    total = exp_n * (L + 1);
    for (int j = 0; j <= total + 1; j++) begin
      pv = sel ? probe1 : probe0;   rs = sel ? result1 : result0;
      bz = sel ? busy1 : busy0;     dn = sel ? done1 : done0;
      fd = sel ? found1 : found0;   er = sel ? err1 : err0;
      np = sel ? nprobe1 : nprobe0;
      if (dn && done_j < 0) done_j = j;
      if (j == 0) first_probe = pv;
      if (j < total) begin
        chk("busy_run", bz, 1);
        chk("done_early", dn, 0);
        chk("probe", pv, exp_q[j / (L + 1)]);
        chk("nprobe_run", np, j / (L + 1));
      end else if (j == total) begin
        chk("busy_done", bz, 0);
        chk("done_pulse", dn, 1);
        chk("found", fd, exp_found);
        chk("err", er, exp_err);
        chk("nprobe_final", np, exp_n);
        chk("probe_last", pv, exp_q[exp_q.size() - 1]);
        if (exp_res_valid) chk("result", rs, exp_result);
      end else begin
        chk("done_one_cycle", dn, 0);
        chk("found_held", fd, exp_found);
        chk("err_held", er, exp_err);
        chk("probe_held", pv, exp_q[exp_q.size() - 1]);
      end
      if (poke && j == 4) begin
        if (sel) start1 = 1'b1; else start0 = 1'b1;
      end else begin
        start0 = 1'b0; start1 = 1'b0;
      end
      @(negedge clk);
    end
    start0 = 1'b0; start1 = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    mode = 0; tgt = 8'h00; tsgn = 1'b0;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_probe", probe0, 8'h00);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_found", found0, 0);
    chk("rst_err", err0, 0);
    chk("rst_result", result0, 8'h00);
    chk("rst_nprobe", nprobe0, 0);
    chk("rst_busy1", busy1, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 8'h00, 1'b0, 0, 0);
    chk("t1_nprobe", nprobe0, 8);
    chk("t1_result", result0, 8'h00);
    chk("t1_found", found0, 1);
    chk("t1_first", first_probe, 8'h7F);

    run(0, 8'hFF, 1'b0, 0, 0);
    chk("t2_nprobe", nprobe0, 9);
    chk("t2_done_cycle", done_j, 9);
    chk("t2_result", result0, 8'hFF);

    run(0, 8'h80, 1'b1, 0, 0);
    chk("t3_first", first_probe, 8'hFF);
    chk("t3_last", probe0, 8'h80);
    chk("t3_nprobe", nprobe0, 8);
    chk("t3_result", result0, 8'h80);
    run(0, 8'h7F, 1'b1, 0, 0);
    chk("t3b_nprobe", nprobe0, 9);
    chk("t3b_result", result0, 8'h7F);

    run(0, 8'h33, 1'b0, 1, 0);
    chk("t4_nprobe", nprobe0, 1);
    chk("t4_err", err0, 1);
    chk("t4_found", found0, 0);
    chk("t4_result", result0, 8'h7F);

    run(1, 8'h40, 1'b0, 0, 1);
    chk("t5_found", found1, 1);
    chk("t5_result", result1, 8'h40);

    run(0, 8'h5A, 1'b0, 0, 0);
    run(0, 8'hC3, 1'b1, 0, 1);
    run(1, 8'h9E, 1'b1, 0, 0);
    run(0, 8'h00, 1'b0, 2, 0);
    chk("gt_exhaust_nprobe", nprobe0, 9);
    chk("gt_exhaust_err", err0, 1);
    run(0, 8'h00, 1'b0, 3, 0);
    chk("lt_exhaust_nprobe", nprobe0, 8);
    run(0, 8'h00, 1'b0, 4, 0);
    chk("noflag_err", err0, 1);

    // Reset while the fourth probe is on the bus abandons the search silently.
    build_model(8'h55, 1'b0, 0);
    tgt = 8'h55; tsgn = 1'b0; mode = 0;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk("t6_probe", probe0, exp_q[j]);
      @(negedge clk);
    end
    chk("t6_probe4", probe0, exp_q[3]);
    chk("t6_busy_before", busy0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_busy", busy0, 0);
    chk("t6_probe_rst", probe0, 8'h00);
    chk("t6_nprobe", nprobe0, 0);
    chk("t6_done", done0, 0);
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      chk("t6_no_done", done0, 0);
    end
    run(0, 8'h55, 1'b0, 0, 0);
    chk("t6_after_result", result0, 8'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
